// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared definitions for the multi-channel SPI DAC driver.
//   - dac_state_t : scheduler FSM states
//   - FRAME_W, CMD_WRITE_UPDATE, ADDR_ALL : DAC frame constants
//   - build_frame : assembles one 32-bit DAC command frame
package dac_spi_pkg;

    localparam int          FRAME_W          = 32;
    localparam logic [3:0]  CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0]  ADDR_ALL         = 4'hF;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } dac_state_t;

    // {8 don't-care, cmd, addr, 12-bit data, 4 don't-care}
    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  addr,
                                                       input logic [11:0] data12);
        return {8'h00, CMD_WRITE_UPDATE, addr, data12, 4'h0};
    endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// spi_shift_tx: generic SCK divider plus MSB-first frame shifter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle request, accepted when not busy
//   frame      : word to transmit, captured with start
//   busy       : high while a frame is on the wire
//   last       : one-cycle pulse on the edge the frame ends (cs_n rises)
//   sck        : SPI clock, idle low, low phase first
//   mosi       : serial data, updated on the falling sck edge
//   cs_n       : chip select, active low
module spi_shift_tx #(
    parameter int SCK_DIV = 1,
    parameter int FRAME_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               last,
    output logic               sck,
    output logic               mosi,
    output logic               cs_n
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] shreg;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            last    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            last <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    cs_n    <= 1'b0;
                    sck     <= 1'b0;
                    shreg   <= frame;
                    mosi    <= frame[FRAME_W-1];
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
            end else if (div_cnt == DIV_W'(SCK_DIV - 1)) begin
                div_cnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    // falling edge: either end the frame or present the next bit
                    sck <= 1'b0;
                    if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                        busy <= 1'b0;
                        cs_n <= 1'b1;
                        mosi <= 1'b0;
                        last <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                        mosi    <= shreg[FRAME_W-2];
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_spi_multi.sv
// dac_spi_multi: multi-channel 12-bit SPI DAC driver.
// On a zero strobe, latches all samples and enables, then sends one
// write-and-update frame per enabled channel in ascending order.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   value     : packed samples, channel k at [k*DATA_W +: DATA_W]
//   chan_en   : per-channel enable, sampled with zero
//   zero      : one-cycle trigger, ignored while busy
//   bcast     : (DAC_BROADCAST_EN only) send channel 0 to all DACs
//   busy      : high during the clear sequence or a frame sequence
//   done      : one-cycle pulse at sequence completion
//   spi_mosi, spi_sck, dac_cs : SPI bus (dac_cs active low)
//   dac_clr   : DAC clear, active low, pulsed after reset
// Optional feature macro: DAC_BROADCAST_EN
module dac_spi_multi
    import dac_spi_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_W     = 12,
    parameter int SCK_DIV    = 1,
    parameter int GAP_CYCLES = 2,
    parameter int CLR_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*DATA_W-1:0] value,
    input  logic [CHANNELS-1:0]        chan_en,
    input  logic                       zero,
`ifdef DAC_BROADCAST_EN
    input  logic                       bcast,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       spi_mosi,
    output logic                       spi_sck,
    output logic                       dac_cs,
    output logic                       dac_clr
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    dac_state_t                  state;
    logic [CLR_W-1:0]            clr_cnt;
    logic [GAP_W-1:0]            gap_cnt;
    logic [CHANNELS*DATA_W-1:0]  val_sh;
    logic [CHANNELS-1:0]         pend;
    logic                        bc_sh;
    logic                        bc_req;
    logic                        tx_start;
    logic [FRAME_W-1:0]          tx_frame;
    logic                        tx_busy;
    logic                        tx_last;

    logic [CH_W-1:0]             low_idx;
    logic [CH_W-1:0]             sel_idx;
    logic [DATA_W-1:0]           sample;
    logic [11:0]                 data12;
    logic [3:0]                  addr;

`ifdef DAC_BROADCAST_EN
    assign bc_req = bcast;
`else
    assign bc_req = 1'b0;
`endif

    // lowest pending channel
    always_comb begin
        low_idx = '0;
        for (int unsigned i = CHANNELS; i > 0; i--) begin
            if (pend[i-1]) low_idx = CH_W'(i - 1);
        end
    end

    always_comb begin
        sel_idx = bc_sh ? '0 : low_idx;
        sample  = val_sh[int'(sel_idx)*DATA_W +: DATA_W];
        data12  = 12'(sample) << (12 - DATA_W);
        addr    = bc_sh ? ADDR_ALL : 4'(low_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLR;
            clr_cnt  <= '0;
            gap_cnt  <= '0;
            dac_clr  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            tx_start <= 1'b0;
            tx_frame <= '0;
            val_sh   <= '0;
            pend     <= '0;
            bc_sh    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_CLR: begin
                    if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                        dac_clr <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (zero) begin
                        val_sh <= value;
                        pend   <= bc_req ? '0 : chan_en;
                        bc_sh  <= bc_req;
                        busy   <= 1'b1;
                        if (bc_req || (chan_en != '0)) begin
                            state <= ST_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    tx_frame <= build_frame(addr, data12);
                    tx_start <= 1'b1;
                    if (!bc_sh) pend[low_idx] <= 1'b0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tx_last && !tx_busy) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        if (pend != '0) begin
                            state <= ST_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_CLR;
            endcase
        end
    end

    spi_shift_tx #(
        .SCK_DIV (SCK_DIV),
        .FRAME_W (FRAME_W)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .frame (tx_frame),
        .busy  (tx_busy),
        .last  (tx_last),
        .sck   (spi_sck),
        .mosi  (spi_mosi),
        .cs_n  (dac_cs)
    );

endmodule

// File: tb/tb_dac_spi_multi.sv
// tb_dac_spi_multi: two DUT instances (SCK_DIV 1 and 2) driven in parallel.
// A per-instance monitor checks every cycle's bus waveform against the
// frames predicted from the sampled inputs.
module tb_dac_spi_multi;

    localparam int CH  = 4;
    localparam int DW  = 12;
    localparam int GAP = 2;
    localparam int CLR = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CH*DW-1:0] value = '0;
    logic [CH-1:0]  chan_en = '0;
    logic           zero = 1'b0;
`ifdef DAC_BROADCAST_EN
    logic           bcast = 1'b0;
`endif
    logic           busy_o [2];
    logic           done_o [2];
    logic           mosi   [2];
    logic           sck    [2];
    logic           cs     [2];
    logic           clr    [2];

    logic           rst_seen = 1'b0;
    int             n_vec = 0;
    int             n_err = 0;
    logic [31:0]    exp_frames[$];
    int             fidx[2];
    int             done_cnt[2];

    always #5 clk = ~clk;
    always @(posedge clk) rst_seen <= rst;

    for (genvar g = 0; g < 2; g++) begin : dut
        dac_spi_multi #(
            .CHANNELS   (CH),
            .DATA_W     (DW),
            .SCK_DIV    (g + 1),
            .GAP_CYCLES (GAP),
            .CLR_CYCLES (CLR)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .value    (value),
            .chan_en  (chan_en),
            .zero     (zero),
`ifdef DAC_BROADCAST_EN
            .bcast    (bcast),
`endif
            .busy     (busy_o[g]),
            .done     (done_o[g]),
            .spi_mosi (mosi[g]),
            .spi_sck  (sck[g]),
            .dac_cs   (cs[g]),
            .dac_clr  (clr[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_frame(input logic [3:0] a, input logic [11:0] d);
        return (32'd3 << 20) | (32'(a) << 16) | (32'(d) << 4);
    endfunction

    // waveform monitor per instance
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int D = g + 1;
        int          k = 0;
        int          hi = 1000;
        bit          in_frame = 0;
        bit          prev_done = 0;
        logic [31:0] cur = '0;

        always @(negedge clk) begin
            if (rst_seen) begin
                chk("rst_cs", g, cs[g], 1);
                chk("rst_sck", g, sck[g], 0);
                chk("rst_mosi", g, mosi[g], 0);
                chk("rst_clr", g, clr[g], 0);
                chk("rst_busy", g, busy_o[g], 1);
                chk("rst_done", g, done_o[g], 0);
                in_frame = 0;
                hi = 1000;
                prev_done = 0;
                fidx[g] = exp_frames.size();
            end else begin
                if (prev_done) chk("busy_after_done", g, busy_o[g], 0);
                if (done_o[g]) begin
                    done_cnt[g]++;
                    chk("done_width", g, prev_done, 0);
                    chk("done_after_frames", g, (fidx[g] == exp_frames.size()) && !in_frame, 1);
                end
                prev_done = done_o[g];
                if (!in_frame && !cs[g]) begin
                    chk("gap_len_ok", g, hi >= GAP, 1);
                    chk("frame_expected", g, fidx[g] < exp_frames.size(), 1);
                    cur = (fidx[g] < exp_frames.size()) ? exp_frames[fidx[g]] : 32'hx;
                    fidx[g]++;
                    in_frame = 1;
                    k = 0;
                end
                if (in_frame) begin
                    if (k == 64 * D) begin
                        chk("frame_end_cs", g, cs[g], 1);
                        chk("frame_end_sck", g, sck[g], 0);
                        in_frame = 0;
                        hi = 1;
                    end else begin
                        chk("frame_cs", g, cs[g], 0);
                        chk("frame_sck", g, sck[g], (k / D) % 2);
                        chk("frame_mosi", g, mosi[g], cur[31 - k / (2 * D)]);
                        chk("frame_busy", g, busy_o[g], 1);
                        k++;
                    end
                end else begin
                    chk("idle_sck", g, sck[g], 0);
                    hi++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        int c0 = 0;
        int c1 = 0;
        rst = 1'b1;
        zero = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        repeat (CLR + 4) begin
            @(negedge clk);
            if (!clr[0]) c0++;
            if (!clr[1]) c1++;
            for (int g = 0; g < 2; g++) begin
                chk("clr_busy", g, busy_o[g], !clr[g]);
                chk("clr_cs", g, cs[g], 1);
                chk("clr_sck", g, sck[g], 0);
            end
        end
        chk("clr_len", 0, c0, CLR);
        chk("clr_len", 1, c1, CLR);
        tick();
    endtask

    task automatic run_seq(input logic [3:0] en, input logic [CH*DW-1:0] vals, input bit bc, input bit disturb);
        int t0 = done_cnt[0];
        int t1 = done_cnt[1];
        int nfr = 0;
        int c = 0;
        value = vals;
        chan_en = en;
`ifdef DAC_BROADCAST_EN
        bcast = bc;
`endif
        if (bc) begin
            exp_frames.push_back(model_frame(4'hF, vals[11:0]));
            nfr = 1;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (en[i]) begin
                    exp_frames.push_back(model_frame(4'(i), vals[i*DW +: DW]));
                    nfr++;
                end
            end
        end
        zero = 1'b1;
        tick();
        zero = 1'b0;
        // later input changes must not reach the frames in flight
        value = 48'({$urandom, $urandom});
        chan_en = 4'($urandom);
`ifdef DAC_BROADCAST_EN
        bcast = 1'b0;
`endif
        @(negedge clk);
        if (nfr == 0) begin
            chk("done_next_cycle", 0, done_o[0], 1);
            chk("done_next_cycle", 1, done_o[1], 1);
        end else begin
            chk("latency_n", 0, cs[0], 1);
            @(negedge clk);
            chk("latency_n1", 0, cs[0], 1);
            chk("latency_n1", 1, cs[1], 1);
            @(negedge clk);
            chk("latency_n2", 0, cs[0], 0);
            chk("latency_n2", 1, cs[1], 0);
        end
        if (disturb) begin
            repeat (40) @(negedge clk);
            chan_en = 4'hF;
            zero = 1'b1;
            @(negedge clk);
            zero = 1'b0;
        end
        while (!(done_cnt[0] > t0 && done_cnt[1] > t1) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("seq_done", 0, done_cnt[0] - t0, 1);
        chk("seq_done", 1, done_cnt[1] - t1, 1);
        repeat (30) @(negedge clk);
        chk("frames_sent", 0, fidx[0], exp_frames.size());
        chk("frames_sent", 1, fidx[1], exp_frames.size());
        tick();
    endtask

    initial begin
        int c;
        fidx[0] = 0; fidx[1] = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;

        chk("model_pin_ch2", 0, model_frame(4'd2, 12'h555), 32'h0032_5550);
        chk("model_pin_ch3", 0, model_frame(4'd3, 12'hFFF), 32'h0033_FFF0);
        chk("model_pin_all", 0, model_frame(4'hF, 12'h123), 32'h003F_1230);

        do_reset(3);

        // single channel 2
        run_seq(4'b0100, {12'h0, 12'h555, 12'h0, 12'h0}, 1'b0, 1'b0);
        // all channels, order 0..3
        run_seq(4'hF, {12'hFFF, 12'hABC, 12'h800, 12'h001}, 1'b0, 1'b0);
        // nothing enabled
        run_seq(4'h0, 48'h123456789ABC, 1'b0, 1'b0);
        // zero during shift is ignored
        run_seq(4'b0001, 48'hFFF_FFF_FFF_A5A, 1'b0, 1'b1);
`ifdef DAC_BROADCAST_EN
        run_seq(4'h0, {12'h0, 12'h0, 12'h0, 12'h123}, 1'b1, 1'b0);
`endif

        // reset in the middle of bit 15
        exp_frames.push_back(model_frame(4'd1, 12'h3C3));
        value = {12'h0, 12'h0, 12'h3C3, 12'h0};
        chan_en = 4'b0010;
        zero = 1'b1;
        tick();
        zero = 1'b0;
        c = 0;
        while (cs[0] && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("abort_frame_started", 0, cs[0], 0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_cs", 0, cs[0], 1);
        chk("abort_sck", 0, sck[0], 0);
        chk("abort_cs", 1, cs[1], 1);
        do_reset(2);
        run_seq(4'b0010, {12'h0, 12'h0, 12'h3C3, 12'h0}, 1'b0, 1'b0);

        // randomized sequences
        for (int r = 0; r < 8; r++) begin
            run_seq(4'($urandom), 48'({$urandom, $urandom}), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dac_spi_multi.md
Name: dac_spi_multi

Overview:
- Parametrised successor to the single-channel DAC FSM.
- Drives a 4-channel, 12-bit SPI DAC (32-bit frame: 8 don't-care, 4 cmd, 4 addr, 12 data, 4 don't-care).
- On a `zero` strobe, latches one sample per channel and sends one write-and-update frame per enabled channel, in ascending channel order.
- Adds a programmable SCK divider, a power-up clear sequence, busy/done status and per-channel enables.

Parameters:
- CHANNELS, 4: number of DAC channels, 1..4; address = channel index.
- DATA_W, 12: sample width, 1..12; left-justified into the 12-bit data field, LSBs zero-filled.
- SCK_DIV, 1: SCK half-period in clk cycles, >=1.
- GAP_CYCLES, 2: minimum dac_cs high time between frames, >=1.
- CLR_CYCLES, 4: dac_clr low duration after reset, >=1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  CHANNELS*DATA_W  packed samples; channel k at [k*DATA_W +: DATA_W].
- chan_en  input  CHANNELS  per-channel enable, sampled with zero.
- zero  input  1  one-cycle trigger strobe.
- busy  output  1  high while CLR or a frame sequence is in progress.
- done  output  1  one-cycle pulse when the sequence completes.
- spi_mosi  output  1  serial data, MSB first.
- spi_sck  output  1  SPI clock, idle low.
- dac_cs  output  1  chip select, active low.
- dac_clr  output  1  DAC clear, active low.

Behaviour:
- Reset (rst high at an edge):
  - State CLR; dac_cs=1, spi_sck=0, spi_mosi=0, dac_clr=0, busy=1, done=0.
  - Valid mid-frame: the frame is aborted immediately and no partial update is completed.
- CLR: dac_clr held 0 for CLR_CYCLES cycles after rst deasserts, then dac_clr=1, busy=0, go to IDLE.
- IDLE:
  - zero=1 latches value and chan_en into shadow registers and selects the lowest enabled channel.
  - If chan_en==0: no frame is sent; done pulses on the next cycle.
- zero while busy (including CLR) is ignored; no queuing.
- LOAD (1 cycle): build frame = {8'h00, 4'b0011, addr[3:0], sample<<(12-DATA_W), 4'h0}.
- SHIFT:
  - dac_cs=0 and spi_mosi=frame[31] from the first SHIFT cycle.
  - spi_sck toggles every SCK_DIV cycles: low phase first, then high phase.
  - spi_mosi changes only while sck is low; the DAC samples it on sck rising.
  - Exactly 32 rising edges per frame; one frame lasts 64*SCK_DIV cycles.
  - After the 32nd high phase, sck returns to 0 and dac_cs=1 on the same edge.
- GAP: dac_cs high for GAP_CYCLES cycles, then LOAD for the next enabled channel, or DONE if none remain.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Latency: zero at edge N -> LOAD at N+1 -> dac_cs low at N+2.
- Shadow registers isolate the frames from value/chan_en changes during a sequence.
- Bit counter 0..31 and divider counter wrap cleanly; no sck glitch at frame boundaries.

Optional Feature:
- Macro DAC_BROADCAST_EN.
- Defined:
  - Adds input port bcast (1 bit), sampled with zero.
  - bcast=1 sends a single frame with addr 4'hF (all DACs) carrying channel 0's sample, ignoring chan_en; done follows that frame.
  - An all-zero chan_en is irrelevant when bcast=1.
- Not defined: port absent; behaviour exactly as above.

Decomposition:
- Package dac_spi_pkg holds:
  - FSM state encoding (CLR, IDLE, LOAD, SHIFT, GAP, DONE)
  - FRAME_W=32, CMD_WRITE_UPDATE=4'b0011, ADDR_ALL=4'hF
- Sub-module spi_shift_tx:
  - Generic SCK divider plus 32-bit MSB-first shifter.
  - Interface: start, frame, busy/last, sck, mosi, cs_n.
- The top holds the channel scheduler, CLR sequencing and status.

Test Plan:
- Power-up: rst high 3 cycles, then low -> dac_clr=0 for exactly 4 cycles then 1; busy falls with dac_clr rise; no sck activity; dac_cs=1.
- Single channel (CHANNELS=4, SCK_DIV=1, chan_en=4'b0100, ch2=12'h555, zero pulse):
  - One frame decodes to 32'h0032_5550.
  - 32 sck rises; dac_cs low 64 cycles; done pulse 1 cycle after the GAP.
- All channels (chan_en=4'hF, values 12'h001/12'h800/12'hABC/12'hFFF, SCK_DIV=2):
  - Four frames with addr 0..3 in order, each 128 cycles.
  - dac_cs high >=2 cycles between frames.
  - value changed mid-sequence has no effect.
- Edge triggers:
  - chan_en=0 with zero -> done next cycle, dac_cs stays 1.
  - zero during SHIFT -> ignored, exactly one sequence sent.
- Reset at bit 15 of a frame -> same edge: dac_cs=1, sck=0; CLR sequence reruns; next zero produces a complete, correct frame.
- DAC_BROADCAST_EN: bcast=1, ch0=12'h123 -> single frame 32'h003F_1230; without the macro the build has no bcast port.
